// File: rtl/spi_m.sv
// SPI master: one byte per transfer, MSB first, programmable sclk half-period
// and CPOL/CPHA mode latched at start.
module spi_m (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  din,
  input  logic [15:0] dvsr,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        miso,
  output logic [7:0]  dout,
  output logic        sclk,
  output logic        mosi,
  output logic        done,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, CPHA_DELAY, P0, P1} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] dvsr_r, dvsr_n;
  logic [2:0]  bitn, bitn_n;
  logic [7:0]  tx, tx_n;
  logic [7:0]  rx, rx_n;
  logic        cpol_r, cpol_n;
  logic        cpha_r, cpha_n;
  logic        done_r, done_n;
  logic        last;
  logic        pclk;

  assign last = (cnt == dvsr_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dvsr_n  = dvsr_r;
    bitn_n  = bitn;
    tx_n    = tx;
    rx_n    = rx;
    cpol_n  = cpol_r;
    cpha_n  = cpha_r;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          tx_n    = din;
          dvsr_n  = dvsr;
          cpol_n  = cpol;
          cpha_n  = cpha;
          cnt_n   = '0;
          bitn_n  = '0;
          state_n = cpha ? CPHA_DELAY : P0;
        end
      end
      CPHA_DELAY: begin
        if (last) begin
          cnt_n   = '0;
          state_n = P0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      P0: begin
        if (last) begin
          rx_n    = {rx[6:0], miso};
          cnt_n   = '0;
          state_n = P1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      P1: begin
        if (last) begin
          cnt_n = '0;
          if (bitn == 3'd7) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            tx_n    = {tx[6:0], 1'b0};
            bitn_n  = bitn + 3'd1;
            state_n = P0;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      dvsr_r <= '0;
      bitn   <= '0;
      tx     <= '0;
      rx     <= '0;
      cpol_r <= 1'b0;
      cpha_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      dvsr_r <= dvsr_n;
      bitn   <= bitn_n;
      tx     <= tx_n;
      rx     <= rx_n;
      cpol_r <= cpol_n;
      cpha_r <= cpha_n;
      done_r <= done_n;
    end
  end

  // pclk is the mode-0 clock; cpol only inverts it, so idle states sit at cpol
  assign pclk  = ((state == P1) && !cpha_r) || ((state == P0) && cpha_r);
  assign sclk  = pclk ^ cpol_r;
  assign mosi  = tx[7];
  assign dout  = rx;
  assign done  = done_r;
  assign ready = (state == IDLE);

endmodule

// File: tb/tb_spi_m.sv
// Scoreboard bench for spi_m: each launched transfer pushes its expected
// results; a negedge monitor checks them when done pulses.
module tb_spi_m;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  din = '0;
  logic [15:0] dvsr = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        miso;
  logic [7:0]  dout;
  logic        sclk, mosi, done, ready;

  logic        lp = 1'b0;
  logic [7:0]  pat = '0;
  logic        miso_v = 1'b0;

  assign miso = lp ? mosi : miso_v;

  spi_m dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .dvsr(dvsr),
    .cpol(cpol), .cpha(cpha), .miso(miso), .dout(dout), .sclk(sclk),
    .mosi(mosi), .done(done), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dout;
    logic [7:0] mosi;
    int         len;
    int         first;
    logic       cpol;
    logic       cpha;
  } exp_t;

  exp_t q[$];
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor state
  int         cyc = 0, t0 = 0, nlead = 0, lowcnt = 0, first = 0;
  logic [7:0] mosi_sh = '0;
  logic       prev_sclk = 1'b0;

  initial begin
    exp_t e;
    logic lead;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        if (sclk !== prev_sclk) begin
          lead = (sclk != q[0].cpol);
          if (lead) begin
            nlead++;
            if (nlead == 1) first = cyc - t0;
            miso_v = (nlead < 8) ? pat[7 - nlead] : 1'b0;
          end
          if (lead ^ q[0].cpha) mosi_sh = {mosi_sh[6:0], mosi};
        end
        if (!ready) lowcnt++;
      end
      if (done === 1'b1) begin
        if (q.size() == 0) chk("spurious_done", 32'(done), 32'd0);
        else begin
          e = q.pop_front();
          chk("dout",      32'(dout),    32'(e.dout));
          chk("mosi_bits", 32'(mosi_sh), 32'(e.mosi));
          chk("length",    cyc - t0,     e.len);
          chk("ready_low", lowcnt,       e.len - 1);
          chk("edges",     nlead,        32'd8);
          chk("first_edge", first,       e.first);
          chk("sclk_idle", 32'(sclk),    32'(e.cpol));
          chk("ready_at_done", 32'(ready), 32'd1);
        end
      end
      prev_sclk = sclk;
      if (start && ready && rst) begin
        t0 = cyc; nlead = 0; lowcnt = 0; first = 0; mosi_sh = '0;
        miso_v = pat[7];
      end
    end
  end

  task automatic launch(input logic [7:0] d, input logic [15:0] dv, input logic po,
                        input logic ph, input logic loop, input logic [7:0] pt);
    exp_t e;
    @(posedge clk); #2;
    din = d; dvsr = dv; cpol = po; cpha = ph; lp = loop; pat = pt; start = 1'b1;
    e.dout  = loop ? d : pt;
    e.mosi  = d;
    e.len   = (ph ? 17 : 16) * (int'(dv) + 1) + 1;
    e.first = int'(dv) + 2;
    e.cpol  = po;
    e.cpha  = ph;
    q.push_back(e);
    @(posedge clk); #2;
    start = 1'b0;
    din = '0; dvsr = '0; cpol = 1'b0; cpha = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int n;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sclk",  32'(sclk),  32'd0);
    chk("rst_mosi",  32'(mosi),  32'd0);
    chk("rst_dout",  32'(dout),  32'd0);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_sclk",  32'(sclk),  32'd0);

    // mode 0, slow clock, miso stuck high
    launch(8'h64, 16'd49, 1'b0, 1'b0, 1'b0, 8'hFF);
    wait_idle();

    // mode 3, loopback
    launch(8'hA5, 16'd1, 1'b1, 1'b1, 1'b1, 8'h00);
    @(negedge clk);
    chk("cpol1_idle_high", 32'(sclk), 32'd1);
    wait_idle();

    // fastest clock, alternating miso
    launch(8'h3C, 16'd0, 1'b0, 1'b0, 1'b0, 8'hAA);
    wait_idle();

    // mode 1 and mode 2 loopback
    launch(8'h96, 16'd2, 1'b0, 1'b1, 1'b1, 8'h00);
    wait_idle();
    launch(8'h4B, 16'd0, 1'b1, 1'b0, 1'b1, 8'h00);
    wait_idle();

    // start during a transfer is ignored
    launch(8'h5A, 16'd3, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (20) @(posedge clk);
    #2 din = 8'hFF; dvsr = 16'd7; cpol = 1'b1; start = 1'b1;
    chk("busy_ready", 32'(ready), 32'd0);
    @(posedge clk); #2 start = 1'b0; din = '0; dvsr = '0; cpol = 1'b0;
    wait_idle();
    repeat (60) @(posedge clk);

    // start on the done cycle is accepted
    launch(8'hC3, 16'd1, 1'b0, 1'b0, 1'b1, 8'h00);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!done && n < 2000);
    chk("b2b_done_seen", 32'(done), 32'd1);
    din = 8'h17; dvsr = 16'd1; cpol = 1'b0; cpha = 1'b1; lp = 1'b1; start = 1'b1;
    begin
      exp_t e;
      e.dout = 8'h17; e.mosi = 8'h17; e.len = 17 * 2 + 1; e.first = 3;
      e.cpol = 1'b0; e.cpha = 1'b1;
      q.push_back(e);
    end
    @(posedge clk); #2 start = 1'b0;
    wait_idle();

    // reset mid-transfer aborts with no done
    launch(8'h5A, 16'd3, 1'b1, 1'b0, 1'b0, 8'hF0);
    n = 0;
    while (nlead < 3 && n < 500) begin @(posedge clk); n++; end
    chk("reach_bit3", 32'(nlead >= 3), 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    q.delete();
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done",  32'(done),  32'd0);
    chk("abort_sclk",  32'(sclk),  32'd0);
    chk("abort_mosi",  32'(mosi),  32'd0);
    chk("abort_dout",  32'(dout),  32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (40) @(posedge clk);
    launch(8'h81, 16'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/spi_m.md
SPI_M -- requirements
Module: spi_m

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  transfer request; accepted only while ready=1.
REQ-005 din  input  8  byte to transmit, MSB first.
REQ-006 dvsr  input  16  half-period divisor; each sclk half-period SHALL last dvsr+1 clk cycles.
REQ-007 cpol  input  1  sclk idle level.
REQ-008 cpha  input  1  0: sample on leading sclk edge; 1: sample on trailing sclk edge.
REQ-009 miso  input  1  serial data from slave.
REQ-010 dout  output  8  received byte.
REQ-011 sclk  output  1  SPI serial clock.
REQ-012 mosi  output  1  serial data to slave.
REQ-013 done  output  1  one-cycle pulse at transfer completion.
REQ-014 ready  output  1  high when idle and able to accept start.

Function
REQ-015 FSM states SHALL be IDLE, CPHA_DELAY, P0 (first half-bit), P1 (second half-bit).
REQ-016 IDLE: ready=1; on start=1 SHALL latch din into tx shift reg, latch dvsr, cpol, cpha into mode regs, clear cycle counter and bit counter, go to P0 if cpha=0, else CPHA_DELAY.
REQ-017 start while ready=0 SHALL be ignored; din/dvsr/cpol/cpha changes mid-transfer SHALL have no effect.
REQ-018 Cycle counter SHALL count 0..dvsr within each of CPHA_DELAY, P0, P1; a phase ends on the cycle the counter equals latched dvsr, and the counter SHALL clear on each phase change.
REQ-019 CPHA_DELAY SHALL last dvsr+1 cycles, then go to P0.
REQ-020 On the last cycle of P0, miso SHALL be shifted into the rx reg LSB (shift left), then go to P1.
REQ-021 On the last cycle of P1: if bit counter=7, go to IDLE and pulse done; else shift tx reg left by one, increment bit counter, go to P0.
REQ-022 mosi SHALL equal tx reg bit 7 at all times (din[7] from the cycle after start).
REQ-023 Internal pclk SHALL be 1 when (state=P1 and cpha=0) or (state=P0 and cpha=1), else 0; sclk SHALL equal pclk XOR latched cpol.
REQ-024 In IDLE and CPHA_DELAY, sclk SHALL equal latched cpol.
REQ-025 dout SHALL equal the rx reg; it holds the last received byte until the next transfer shifts in.
REQ-026 done SHALL be high exactly one cycle: the first IDLE cycle after the final P1, coincident with ready returning to 1.
REQ-027 ready SHALL be 0 from the cycle after an accepted start until that done cycle.
REQ-028 Transfer length from accepted start to done SHALL be 16*(dvsr+1)+1 cycles for cpha=0 and 17*(dvsr+1)+1 for cpha=1.
REQ-029 dvsr=0 SHALL be legal: each half-period is one clk cycle.
REQ-030 start asserted on the same cycle as done SHALL be accepted and begin a new transfer.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, all counters and shift regs to 0, mode regs to 0; outputs: ready=1, done=0, sclk=0, mosi=0, dout=0x00.
REQ-032 rst asserted mid-transfer SHALL abort it with no done pulse; the next transfer after release SHALL behave normally.

Verification
REQ-033 rst low then high, inputs 0 -> ready=1, done=0, sclk=0, mosi=0, dout=0x00.
REQ-034 cpol=0, cpha=0, dvsr=49, din=0x64, miso=1, start one cycle -> ready low 800 cycles; sclk period 100 cycles, 8 pulses; mosi bits 0,1,1,0,0,1,0,0; done one pulse; dout=0xFF.
REQ-035 cpol=1, cpha=1, dvsr=1, din=0xA5, miso looped from mosi -> sclk idles high; 50-cycle CPHA_DELAY absent, 2-cycle delay present; dout=0xA5 at done.
REQ-036 dvsr=0, cpha=0, din=0x3C, miso alternating per bit 1,0,1,0,... -> done 17 cycles after start; dout=0xAA.
REQ-037 start pulsed again mid-transfer with din=0xFF -> ignored; mosi still shows original byte; only one done.
REQ-038 rst asserted at bit 3 -> immediate IDLE, ready=1, no done; following transfer din=0x81 with miso=0 completes with dout=0x00.
